// File: rtl/stall_ctrl_pkg.sv
// Shared opcode constants and FSM state encoding for the pipeline stall controller.
// Opcodes cover the load class and the branch/jump class seen in IF/ID.
package stall_ctrl_pkg;

  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] FN_JALR   = 6'b001001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/stall_ctrl_classify.sv
// Combinational classifier: decodes the IF/ID instruction into a hazard class and
// the number of bubbles that class needs.
module stall_classify
  import stall_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int BR_STALL   = 2
) (
  input  logic [63:0] ifid_reg,
  output logic        is_load,
  output logic [2:0]  len
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_branch;
  logic       unused_cls;

  assign op    = ifid_reg[31:26];
  assign funct = ifid_reg[5:0];

  assign is_load   = is_load_op(op);
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_REGIMM) ||
                     (op == OP_BGTZ) || (op == OP_BLEZ) || (op == OP_JAL) ||
                     ((op == OP_RTYPE) && (funct == FN_JALR));

  // Anything that is not a load (branches, jalr, and any other requester) uses BR_STALL.
  assign len = is_load ? 3'(LOAD_STALL) : 3'(BR_STALL);

  assign unused_cls = ^{ifid_reg[63:32], ifid_reg[25:6], is_branch};

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: turns the 1-bit hazard request into a multi-cycle bubble
// sequence, handles EX redirect flushes and counts stall cycles (saturating).
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int BR_STALL   = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_req,
  input  logic [63:0]      ifid_reg,
  input  logic             redirect,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             stalling,
  output logic [CNT_W-1:0] stall_cycles,
  output state_e           state_dbg
);

  logic             is_load;
  logic [2:0]       len;
  logic             unused_top;
  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             stall_req;

  stall_classify #(
    .LOAD_STALL(LOAD_STALL),
    .BR_STALL  (BR_STALL)
  ) u_classify (
    .ifid_reg(ifid_reg),
    .is_load (is_load),
    .len     (len)
  );

  assign unused_top = is_load;

  assign stall_req = ((state_q == S_IDLE) && hazard_req) || (state_q == S_STALL);

  // Outputs are gated by rst so they show reset values the instant reset asserts.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stalling   = 1'b0;
    if (rst) begin
      if (redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (stall_req) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        stalling   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hazard_req) begin
            cnt_d   = len - 3'd1;
            state_d = (len == 3'd1) ? S_RELEASE : S_STALL;
          end
        end
        S_STALL: begin
          cnt_d   = cnt_q - 3'd1;
          state_d = (cnt_q == 3'd1) ? S_RELEASE : S_STALL;
        end
        // Same instruction still sits in IF/ID here, so hazard_req must not re-trigger.
        S_RELEASE: state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 3'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stalling && (stall_cycles_q != {CNT_W{1'b1}}))
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus randomized traffic,
// all checked against a bubble-count reference model.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  localparam int LS = 1;
  localparam int BS = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hazard_req = 1'b0;
  logic [63:0]   ifid_reg = 64'd0;
  logic          redirect = 1'b0;
  logic          pc_we, ifid_we, ifid_flush, idex_flush, stalling;
  logic [CW-1:0] stall_cycles;
  state_e        state_dbg;

  int total = 0;
  int bad   = 0;

  // Reference model: bubbles still owed, release-cycle pending, stall count.
  int m_rem = 0;
  bit m_rel = 1'b0;
  int m_cnt = 0;

  logic [5:0] ops [11] = '{6'b100011, 6'b100000, 6'b100100, 6'b000100, 6'b000101,
                           6'b000001, 6'b000111, 6'b000110, 6'b000011, 6'b000000,
                           6'b001000};

  stall_ctrl #(
    .LOAD_STALL(LS),
    .BR_STALL  (BS),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard_req  (hazard_req),
    .ifid_reg    (ifid_reg),
    .redirect    (redirect),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .stalling    (stalling),
    .stall_cycles(stall_cycles),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [5:0] op);
    return (op == 6'b100011 || op == 6'b100000 || op == 6'b100100) ? LS : BS;
  endfunction

  task automatic cycle(input logic hz, input logic [5:0] op, input logic [5:0] fn,
                       input logic rd);
    logic [63:0] w;
    logic        e_stall;
    int          e_state;
    @(negedge clk);
    w = {$urandom, $urandom};
    w[31:26] = op;
    w[5:0]   = fn;
    hazard_req = hz;
    ifid_reg   = w;
    redirect   = rd;
    #2;
    e_state = (m_rem > 0) ? 1 : (m_rel ? 2 : 0);
    e_stall = !rd && ((m_rem > 0) || (!m_rel && hz));
    check("state", 32'(state_dbg), e_state);
    check("stall_cycles", 32'(stall_cycles), m_cnt);
    check("pc_we", 32'(pc_we), 32'(!e_stall));
    check("ifid_we", 32'(ifid_we), 32'(!e_stall));
    check("ifid_flush", 32'(ifid_flush), 32'(rd));
    check("idex_flush", 32'(idex_flush), 32'(rd || e_stall));
    check("stalling", 32'(stalling), 32'(e_stall));
    if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    if (rd) begin
      m_rem = 0;
      m_rel = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_rel = (m_rem == 0);
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (hz) begin
      m_rem = len_of(op) - 1;
      m_rel = (m_rem == 0);
    end
  endtask

  // Asserts reset between clock edges and checks the outputs drop back at once.
  task automatic async_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_pc_we", 32'(pc_we), 32'd1);
    check("rst_ifid_we", 32'(ifid_we), 32'd1);
    check("rst_ifid_flush", 32'(ifid_flush), 32'd0);
    check("rst_idex_flush", 32'(idex_flush), 32'd0);
    check("rst_stalling", 32'(stalling), 32'd0);
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    m_rem = 0;
    m_rel = 1'b0;
    m_cnt = 0;
    hazard_req = 1'b0;
    redirect   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic final_count(input string tag, input int exp);
    @(negedge clk);
    #2;
    check(tag, 32'(stall_cycles), exp);
  endtask

  initial begin
    hazard_req = 1'b1;
    redirect   = 1'b1;
    async_reset();

    // lw with one bubble
    cycle(1'b1, 6'b100011, 6'd0, 1'b0);
    cycle(1'b1, 6'b100011, 6'd0, 1'b0);
    cycle(1'b0, 6'b001000, 6'd0, 1'b0);
    final_count("t1_cnt", 1);

    // beq with hazard_req held through the release cycle
    async_reset();
    cycle(1'b1, 6'b000100, 6'd0, 1'b0);
    cycle(1'b1, 6'b000100, 6'd0, 1'b0);
    cycle(1'b1, 6'b000100, 6'd0, 1'b0);
    cycle(1'b0, 6'b001000, 6'd0, 1'b0);
    final_count("t2_cnt", 2);

    // redirect during the second bubble of jal
    async_reset();
    cycle(1'b1, 6'b000011, 6'd0, 1'b0);
    cycle(1'b1, 6'b000011, 6'd0, 1'b1);
    cycle(1'b0, 6'b001000, 6'd0, 1'b0);
    final_count("t3_cnt", 1);

    // lw then beq back-to-back
    async_reset();
    cycle(1'b1, 6'b100011, 6'd0, 1'b0);
    cycle(1'b1, 6'b100011, 6'd0, 1'b0);
    cycle(1'b1, 6'b000100, 6'd0, 1'b0);
    cycle(1'b1, 6'b000100, 6'd0, 1'b0);
    cycle(1'b1, 6'b000100, 6'd0, 1'b0);
    cycle(1'b0, 6'b001000, 6'd0, 1'b0);
    final_count("t4_cnt", 3);

    // jalr through the R-type funct path, then reset mid-stall
    async_reset();
    cycle(1'b1, 6'b000000, 6'b001001, 1'b0);
    async_reset();

    // saturation of the narrow counter
    for (int i = 0; i < 27; i++) cycle(1'b1, 6'b000100, 6'd0, 1'b0);
    cycle(1'b0, 6'b001000, 6'd0, 1'b0);
    final_count("t6_sat", (1 << CW) - 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)),
              ops[$urandom_range(0, 10)],
              ($urandom_range(0, 3) == 0) ? 6'b001001 : 6'($urandom),
              ($urandom_range(0, 9) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
